scramble_seq_checker: RTL and testbench
=======================================

// Module: scramble_seq_checker
// PURPOSE
//  Downstream monitor for the 4-bit scrambled-sequence counter. Samples the counter's
//  code stream, decodes each code to its ordinal, and checks every transition against
//  the fixed 14-step sequence. Reports lock, sequence errors and completed laps to the
//  status/debug logic.
//  Fixed sequence, ordinal 0..13: 8,7,11,4,9,2,5,12,6,3,15,1,14,13; it then wraps to 8.
// PARAMETERS
//  LAP_W       8  width of lap_count
//  LOCK_CNT    3  consecutive STEP samples required in ACQUIRE to declare lock (>=1)
//  ERR_THRESH  2  consecutive BAD samples tolerated in lock before lock is dropped (>=1)
// PORTS
//  clk           in   1      clock, rising edge
//  reset         in   1      reset, synchronous, active-high
//  sample_valid  in   1      code_in is valid this cycle
//  code_in       in   4      scrambled counter value from upstream
//  index_out     out  4      ordinal of the last sampled code; 4'hF if the code is illegal
//  locked        out  1      1 in LOCKED and SLIP states
//  seq_err       out  1      one-cycle pulse on each BAD sample while LOCKED or SLIP
//  lap_pulse     out  1      one-cycle pulse on a STEP from ordinal 13 to ordinal 0 while LOCKED
//  lap_count     out  LAP_W  number of completed laps; wraps modulo 2^LAP_W
// BEHAVIOUR
//  Outputs:
//  - All outputs registered; each updates 1 cycle after the sample_valid cycle.
//  - Without sample_valid, all outputs hold; seq_err and lap_pulse are 0.
//  Reset (synchronous, priority over sample_valid in the same cycle):
//  - state=SEARCH, index_out=4'hF, locked=0, seq_err=0, lap_pulse=0, lap_count=0.
//  - Clears prev, run and miss; prev is marked invalid.
//  Decoding:
//  - Codes 0 and 10 are illegal and decode to ordinal 15.
//  - prev holds the last legal code/ordinal. It updates only on legal samples.
//  - exp = (prev_idx==13) ? 0 : prev_idx+1.
//  Sample classification, first match wins:
//  - HOLD: code equals prev.
//  - STEP: ordinal equals exp.
//  - RESTART: ordinal is 0 (upstream reset or unload forces code 8).
//  - BAD: illegal code, or any other legal code.
//  FSM transitions:
//  - SEARCH: legal sample -> ACQUIRE, run=0. Illegal sample: stay.
//  - ACQUIRE on STEP: run++; when run reaches LOCK_CNT -> LOCKED.
//  - ACQUIRE on HOLD: no change.
//  - ACQUIRE on RESTART: run=0, stay.
//  - ACQUIRE on BAD: -> SEARCH; no seq_err.
//  - LOCKED on STEP or HOLD: stay.
//  - LOCKED on RESTART: stay; no error, no lap.
//  - LOCKED on BAD: seq_err=1, miss=1, -> SLIP. If ERR_THRESH==1, go to SEARCH instead.
//  - SLIP on STEP, HOLD or RESTART: -> LOCKED, miss=0.
//  - SLIP on BAD: seq_err=1, miss++; when miss reaches ERR_THRESH -> SEARCH, locked=0.
//  Laps:
//  - lap_pulse and lap_count++ happen only on a STEP 13->0 in LOCKED.
//  - A STEP in SLIP only restores lock; it does not count a lap.
//  - lap_count is unaffected by loss of lock; only reset clears it.
//  - run and miss saturate at LOCK_CNT and ERR_THRESH respectively.
// STRUCTURE
//  Package scramble_seq_pkg:
//  - SEQ_LEN=14, IDX_ILLEGAL=4'hF.
//  - typedef enum logic[1:0] {SEARCH, ACQUIRE, LOCKED, SLIP} chk_state_t.
//  - typedef enum {HOLD, STEP, RESTART, BAD} sample_cls_t.
//  - Sequence constant table.
//  Sub-module scramble_seq_decode:
//  - Combinational code -> ordinal lookup, plus a legal flag.
//  - Shared with future producers of the same sequence.
//  Top: classifier, FSM, run/miss counters, lap counter, output registers.
// TESTING
//  1. Reset; send 8,7,11,4 back-to-back:
//     index_out 0,1,2,3; locked=1 one cycle after the 4th sample.
//  2. Locked; run a full lap ...,14,13,8:
//     lap_pulse one cycle after the 8; lap_count 0->1.
//     With LAP_W=2, after 4 laps lap_count wraps to 0.
//  3. Locked at 9; send 9 x5, with gaps where sample_valid=0:
//     no seq_err, locked stays 1, index_out=4.
//  4. Locked at 4; send 10, then 9:
//     seq_err pulse, index_out=F, state SLIP; then state LOCKED, index_out=4, no lap.
//  5. Locked at 4, ERR_THRESH=2; send 5, then 3:
//     two seq_err pulses; locked=0 after the 3; state SEARCH.
//  6. Locked at 12; send 8:
//     no seq_err or lap, locked=1.
//     Then reset=1 with sample_valid=1: next cycle all outputs at reset values.

Source files
------------

// File: rtl/scramble_seq_pkg.sv
// Shared definitions for the scrambled 4-bit sequence: ordinal table, state and
// sample-class encodings, and the ordinal successor helper.
package scramble_seq_pkg;

    localparam int         SEQ_LEN     = 14;
    localparam logic [3:0] IDX_ILLEGAL = 4'hF;

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED, SLIP} chk_state_t;
    typedef enum logic [1:0] {HOLD, STEP, RESTART, BAD} sample_cls_t;

    // Entry [i] is the code emitted at ordinal i; ordinal 0 sits in the low nibble.
    localparam logic [SEQ_LEN-1:0][3:0] SEQ_TABLE = {
        4'd13, 4'd14, 4'd1, 4'd15, 4'd3, 4'd6, 4'd12,
        4'd5,  4'd2,  4'd9, 4'd4,  4'd11, 4'd7, 4'd8
    };

    // Ordinal that legally follows o; the last ordinal wraps back to 0.
    function automatic logic [3:0] next_ord(input logic [3:0] o);
        return (o == 4'(SEQ_LEN - 1)) ? 4'd0 : o + 4'd1;
    endfunction

endpackage

// File: rtl/scramble_seq_decode.sv
// Combinational code -> ordinal lookup. Codes absent from the sequence (0 and 10)
// decode to IDX_ILLEGAL with legal low.
module scramble_seq_decode
    import scramble_seq_pkg::*;
(
    input  logic [3:0] code,
    output logic [3:0] idx,
    output logic       legal
);

    // Linear search of the sequence table; each code appears at most once.
    always_comb begin
        idx   = IDX_ILLEGAL;
        legal = 1'b0;
        for (int i = 0; i < SEQ_LEN; i++) begin
            if (code == SEQ_TABLE[i]) begin
                idx   = 4'(i);
                legal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/scramble_seq_checker.sv
// Monitors the scrambled counter stream: decodes each sampled code, classifies the
// transition against the last legal code, and tracks lock, errors and laps.
module scramble_seq_checker
    import scramble_seq_pkg::*;
#(
    parameter int LAP_W      = 8,
    parameter int LOCK_CNT   = 3,
    parameter int ERR_THRESH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_valid,
    input  logic [3:0]       code_in,
    output logic [3:0]       index_out,
    output logic             locked,
    output logic             seq_err,
    output logic             lap_pulse,
    output logic [LAP_W-1:0] lap_count
);

    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(ERR_THRESH + 1);

    chk_state_t        state, state_n;
    sample_cls_t       cls;
    logic [RUN_W-1:0]  run, run_n;
    logic [MISS_W-1:0] miss, miss_n;
    logic              prev_valid;
    logic [3:0]        prev_code, prev_idx;
    logic [3:0]        idx;
    logic              legal;
    logic              err_n, lap_n;

    scramble_seq_decode u_decode (
        .code  (code_in),
        .idx   (idx),
        .legal (legal)
    );

    // Classify the current sample; earlier matches take priority.
    always_comb begin
        cls = BAD;
        if (legal && prev_valid && code_in == prev_code)
            cls = HOLD;
        else if (legal && prev_valid && idx == next_ord(prev_idx))
            cls = STEP;
        else if (legal && idx == 4'd0)
            cls = RESTART;
    end

    // Next state, saturating run/miss counters and the one-cycle pulses.
    always_comb begin
        state_n = state;
        run_n   = run;
        miss_n  = miss;
        err_n   = 1'b0;
        lap_n   = 1'b0;
        if (sample_valid) begin
            unique case (state)
                SEARCH: begin
                    if (legal) begin
                        state_n = ACQUIRE;
                        run_n   = '0;
                    end
                end
                ACQUIRE: begin
                    unique case (cls)
                        STEP: begin
                            if (run >= RUN_W'(LOCK_CNT - 1)) begin
                                run_n   = RUN_W'(LOCK_CNT);
                                state_n = LOCKED;
                            end else begin
                                run_n = run + RUN_W'(1);
                            end
                        end
                        RESTART: run_n   = '0;
                        BAD:     state_n = SEARCH;
                        default: ;
                    endcase
                end
                LOCKED: begin
                    if (cls == STEP && idx == 4'd0)
                        lap_n = 1'b1;
                    if (cls == BAD) begin
                        err_n   = 1'b1;
                        miss_n  = MISS_W'(1);
                        state_n = (ERR_THRESH == 1) ? SEARCH : SLIP;
                    end
                end
                SLIP: begin
                    if (cls == BAD) begin
                        err_n = 1'b1;
                        if (miss >= MISS_W'(ERR_THRESH - 1)) begin
                            miss_n  = MISS_W'(ERR_THRESH);
                            state_n = SEARCH;
                        end else begin
                            miss_n = miss + MISS_W'(1);
                        end
                    end else begin
                        miss_n  = '0;
                        state_n = LOCKED;
                    end
                end
                default: state_n = SEARCH;
            endcase
        end
    end

    // State, history and registered outputs; everything holds when no sample arrives.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SEARCH;
            run        <= '0;
            miss       <= '0;
            prev_valid <= 1'b0;
            prev_code  <= '0;
            prev_idx   <= '0;
            index_out  <= IDX_ILLEGAL;
            locked     <= 1'b0;
            seq_err    <= 1'b0;
            lap_pulse  <= 1'b0;
            lap_count  <= '0;
        end else begin
            state     <= state_n;
            run       <= run_n;
            miss      <= miss_n;
            seq_err   <= err_n;
            lap_pulse <= lap_n;
            if (lap_n)
                lap_count <= lap_count + LAP_W'(1);
            if (sample_valid) begin
                index_out <= idx;
                locked    <= (state_n == LOCKED) || (state_n == SLIP);
                if (legal) begin
                    prev_valid <= 1'b1;
                    prev_code  <= code_in;
                    prev_idx   <= idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_scramble_seq_checker.sv
// Directed bench: a vector table walks lock, error, slip, restart and lap scenarios;
// a second instance with a 2-bit lap counter runs alongside to observe wrap.
module tb_scramble_seq_checker;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [3:0] code;
        logic [3:0] idx;
        logic       lk;
        logic       err;
        logic       lap;
        logic [7:0] lc;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sample_valid = 1'b0;
    logic [3:0] code_in = 4'd0;

    logic [3:0] idx_a, idx_b;
    logic       lk_a, lk_b, err_a, err_b, lap_a, lap_b;
    logic [7:0] lc_a;
    logic [1:0] lc_b;

    int checks = 0;
    int failures = 0;

    vec_t tbl[$];
    int   seq_codes[14] = '{8, 7, 11, 4, 9, 2, 5, 12, 6, 3, 15, 1, 14, 13};

    always #5 clk = ~clk;

    scramble_seq_checker dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .code_in(code_in),
        .index_out(idx_a), .locked(lk_a), .seq_err(err_a), .lap_pulse(lap_a),
        .lap_count(lc_a)
    );

    scramble_seq_checker #(.LAP_W(2)) dut2 (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .code_in(code_in),
        .index_out(idx_b), .locked(lk_b), .seq_err(err_b), .lap_pulse(lap_b),
        .lap_count(lc_b)
    );

    function automatic vec_t mk(input logic rst, input logic vld, input logic [3:0] code,
                                input logic [3:0] idx, input logic lk, input logic err,
                                input logic lap, input logic [7:0] lc);
        vec_t v;
        v.rst = rst; v.vld = vld; v.code = code; v.idx = idx;
        v.lk = lk; v.err = err; v.lap = lap; v.lc = lc;
        return v;
    endfunction

    task automatic chk(input string name, input int n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @vec%0d: got %0h expected %0h", name, n, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int n);
        @(negedge clk);
        reset        = v.rst;
        sample_valid = v.vld;
        code_in      = v.code;
        @(posedge clk);
        #1;
        chk("index_out", n, 32'(idx_a), 32'(v.idx));
        chk("locked",    n, 32'(lk_a),  32'(v.lk));
        chk("seq_err",   n, 32'(err_a), 32'(v.err));
        chk("lap_pulse", n, 32'(lap_a), 32'(v.lap));
        chk("lap_count", n, 32'(lc_a),  32'(v.lc));
        chk("lap_pulse_w2", n, 32'(lap_b), 32'(v.lap));
        chk("lap_count_w2", n, 32'(lc_b),  32'(v.lc[1:0]));
    endtask

    initial begin
        // Reset
        tbl.push_back(mk(1, 0, 0,  4'hF, 0, 0, 0, 0));
        // Acquire: 8,7,11,4 -> lock after the 4th
        tbl.push_back(mk(0, 1, 8,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 7,  1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 11, 2, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4,  3, 1, 0, 0, 0));
        // Locked at 4: illegal 10 -> SLIP with error, then 9 restores lock
        tbl.push_back(mk(0, 1, 10, 4'hF, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 9,  4, 1, 0, 0, 0));
        // Locked at 9: five holds interleaved with idle cycles
        tbl.push_back(mk(0, 1, 9,  4, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 3,  4, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 9,  4, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  4, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 9,  4, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 9,  4, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8,  4, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 9,  4, 1, 0, 0, 0));
        // Advance to 12, then restart with 8: no error, no lap
        tbl.push_back(mk(0, 1, 2,  5, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5,  6, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 12, 7, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8,  0, 1, 0, 0, 0));
        // Four full laps; idle after the first lap pulse
        for (int lap = 1; lap <= 4; lap++) begin
            for (int i = 1; i < 14; i++)
                tbl.push_back(mk(0, 1, 4'(seq_codes[i]), 4'(i), 1, 0, 0, 8'(lap - 1)));
            tbl.push_back(mk(0, 1, 8, 0, 1, 0, 1, 8'(lap)));
            if (lap == 1)
                tbl.push_back(mk(0, 0, 8, 0, 1, 0, 0, 1));
        end
        // Locked at 4: two bad samples drop lock
        tbl.push_back(mk(0, 1, 7,  1, 1, 0, 0, 4));
        tbl.push_back(mk(0, 1, 11, 2, 1, 0, 0, 4));
        tbl.push_back(mk(0, 1, 4,  3, 1, 0, 0, 4));
        tbl.push_back(mk(0, 1, 5,  6, 1, 1, 0, 4));
        tbl.push_back(mk(0, 1, 3,  9, 0, 1, 0, 4));
        tbl.push_back(mk(0, 0, 3,  9, 0, 0, 0, 4));
        // Re-acquire from SEARCH; lap count survives loss of lock
        tbl.push_back(mk(0, 1, 8,  0, 0, 0, 0, 4));
        tbl.push_back(mk(0, 1, 7,  1, 0, 0, 0, 4));
        tbl.push_back(mk(0, 1, 11, 2, 0, 0, 0, 4));
        tbl.push_back(mk(0, 1, 4,  3, 1, 0, 0, 4));
        // Reset wins over a simultaneous valid sample
        tbl.push_back(mk(1, 1, 9,  4'hF, 0, 0, 0, 0));
        // ACQUIRE: restart clears the run, hold leaves it alone
        tbl.push_back(mk(0, 1, 7,  1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 11, 2, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 7,  1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 11, 2, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4,  3, 1, 0, 0, 0));

        foreach (tbl[i])
            run_vec(tbl[i], i);

        // Hand sequence: bad sample in ACQUIRE falls back silently, and the
        // re-entry to ACQUIRE starts counting from zero.
        run_vec(mk(1, 0, 0,  4'hF, 0, 0, 0, 0), 1000);
        run_vec(mk(0, 1, 8,  0, 0, 0, 0, 0), 1001);
        run_vec(mk(0, 1, 7,  1, 0, 0, 0, 0), 1002);
        run_vec(mk(0, 1, 4,  3, 0, 0, 0, 0), 1003);
        run_vec(mk(0, 1, 9,  4, 0, 0, 0, 0), 1004);
        run_vec(mk(0, 1, 2,  5, 0, 0, 0, 0), 1005);
        run_vec(mk(0, 1, 5,  6, 0, 0, 0, 0), 1006);
        run_vec(mk(0, 1, 12, 7, 1, 0, 0, 0), 1007);
        // Hand sequence: single slip recovered by a restart, then a lap from 13 is
        // not reachable directly, so a following bad pair drops lock again.
        run_vec(mk(0, 1, 0,  4'hF, 1, 1, 0, 0), 1008);
        run_vec(mk(0, 1, 8,  0, 1, 0, 0, 0), 1009);
        run_vec(mk(0, 1, 14, 12, 1, 1, 0, 0), 1010);
        run_vec(mk(0, 0, 14, 12, 1, 0, 0, 0), 1011);
        run_vec(mk(0, 1, 10, 4'hF, 0, 1, 0, 0), 1012);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
